// File: rtl/pll_lock_supervisor.sv
// Sequences an EHXPLLL from the reference-clock side: pulses PLL RST, qualifies the
// asynchronous LOCK signal and releases the system reset only after sustained lock.
module pll_lock_supervisor #(
  parameter int unsigned STABLE_CYCLES  = 4800,
  parameter int unsigned RST_CYCLES     = 48,
  parameter int unsigned TIMEOUT_CYCLES = 480000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       clr_flags,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, lock_s_q;
  logic [3:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             retry_inc_s;
  logic             lost_set_s;

  // LOCK is asynchronous to clkin; two flops before anything looks at it.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked_in;
      lock_s_q <= sync1_q;
    end
  end

  // State, shared counter and diagnostic registers.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET_PLL;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state logic; lock takes priority over the timeout in WAIT_LOCK.
  always_comb begin
    state_d     = state_q;
    retry_inc_s = 1'b0;
    lost_set_s  = 1'b0;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else                   state_d = S_RESET_PLL;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_RESET_PLL;
          retry_inc_s = 1'b1;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_STABLE: begin
        if (!lock_s_q)                state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        else                          state_d = S_STABLE;
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d    = S_RESET_PLL;
          lost_set_s = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);

    if (retry_inc_s && (retry_q != 4'd15)) retry_d = retry_q + 4'd1;
    else                                   retry_d = retry_q;

    // A new lock loss outranks a clear request in the same cycle.
    if (lost_set_s)     lost_d = 1'b1;
    else if (clr_flags) lost_d = 1'b0;
    else                lost_d = lost_q;
  end

  // Outputs depend only on registered state.
  always_comb begin
    pll_rst     = (state_q == S_RESET_PLL);
    sys_rst     = (state_q != S_RUN);
    ready       = (state_q == S_RUN);
    retry_count = retry_q;
    lock_lost   = lost_q;
  end

endmodule
